sensor_stim_seq: RTL
====================

# sensor_stim_seq

Parametrised GPIO stimulus sequencer that plays a programmable table of WIDTH-bit patterns, each held for its own programmable number of clock cycles, in one-shot or looping mode. It replaces hand-timed pin toggling in system-level benches and doubles as an on-board sensor emulator driving the `system` GPIO inputs. A small register table is loaded through a write port; `start`/`stop` control playback; status outputs report progress.

## Interface
- `WIDTH`, 8, pattern width in bits (GPIO lines driven)
- `DEPTH`, 8, table entries; power of two, ≥2
- `DWELL_W`, 24, width of per-step dwell count
- `IDLE_VAL`, 0, value of `gpio_out` after reset

- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `load_we`  in  1  table write strobe
- `load_addr`  in  log2(DEPTH)  table entry index
- `load_pattern`  in  WIDTH  pattern to store
- `load_dwell`  in  DWELL_W  hold time in cycles to store
- `num_steps`  in  log2(DEPTH)+1  entries to play, sampled at start
- `loop_en`  in  1  1 = wrap to entry 0 after last step, sampled at start
- `start`  in  1  single-cycle start pulse
- `stop`  in  1  single-cycle abort pulse
- `gpio_out`  out  WIDTH  registered stimulus output
- `busy`  out  1  playback active
- `step_idx`  out  log2(DEPTH)  entry currently driven
- `step_strobe`  out  1  one-cycle pulse when a new entry is applied
- `done`  out  1  one-cycle pulse at end of one-shot playback
- `edge_count`  out  16  see Configuration

## Operation
- States: IDLE, RUN. Reset → IDLE; `gpio_out`=IDLE_VAL, `busy`=0, `step_idx`=0, `step_strobe`=0, `done`=0, `edge_count`=0; table contents undefined after reset (not cleared).
- Table write: `load_we` writes pattern and dwell at `load_addr` at the clock edge; allowed in any state. A write to an entry takes effect the next time that entry is entered; the entry currently driving is not re-applied.
- IDLE + `start`: latch `num_steps` (clamped to DEPTH) and `loop_en`; if latched count is 0, start is ignored. Otherwise → RUN, apply entry 0.
- Applying entry k: `gpio_out`←pattern[k], `step_idx`←k, `step_strobe`=1, dwell counter loaded with max(dwell[k],1).
- RUN: counter decrements each cycle; on expiry apply entry k+1; after last entry: `loop_en`=1 → apply entry 0; `loop_en`=0 → IDLE, `done`=1, `busy`=0, `gpio_out` holds last pattern.
- `stop` in RUN: → IDLE next edge, `gpio_out` holds current value, no `done`. `stop` in IDLE: no effect.
- `start` in RUN: restart from entry 0 with newly latched `num_steps`/`loop_en`. `start` and `stop` same cycle: `stop` wins.
- Dwell arithmetic: unsigned, no overflow; dwell 0 behaves as 1.

## Timing
- `start` sampled at edge N → `gpio_out`=pattern[0], `busy`=1, `step_strobe`=1 visible after edge N+1.
- Entry k drives `gpio_out` for exactly max(dwell[k],1) cycles; consecutive entries are back-to-back with no gap cycle.
- One-shot: `done` and `busy`=0 appear in the cycle immediately after the last entry's final dwell cycle; total playback = sum of effective dwells.
- `stop` at edge M → `busy`=0 after edge M+1.
- `rst` mid-playback: all outputs return to reset values on that edge.

## Configuration
- `SENSOR_STIM_SEQ_EDGE_CNT_EN` defined: `edge_count` counts entry applications where the new pattern differs from the previous `gpio_out`; cleared on accepted `start` and reset; saturates at 16'hFFFF.
- Not defined: no counter logic; `edge_count` tied to 0.

## Test plan
- Reset: assert `rst` 3 cycles mid-playback → `gpio_out`=IDLE_VAL, `busy`=0, `done`=0 on the following cycle.
- One-shot: entries 8'h01/8'h00/8'h01/8'h00/8'h01/8'h00, dwell 2000 each, `num_steps`=6, `loop_en`=0 → each value held exactly 2000 cycles, 6 `step_strobe` pulses, `done` at cycle 12001 after start, `gpio_out` stays 8'h00.
- Loop + wrap: 2 entries 8'hA5 (dwell 3), 8'h5A (dwell 0) → sequence A5,A5,A5,5A repeats indefinitely, `done` never asserted.
- Abort/restart: `stop` during entry 2 → `busy` drops next cycle, output frozen; `start` and `stop` same cycle → no playback; `start` during RUN → entry 0 reapplied next cycle.
- Boundaries: `num_steps`=0 → start ignored; `num_steps`=15 with DEPTH=8 → plays 8 entries; live write to entry 1 while entry 0 plays → new value appears at step 1.
- With `SENSOR_STIM_SEQ_EDGE_CNT_EN`: one-shot scenario above → `edge_count`=6 (IDLE_VAL 0 → 01 counts; 00 repeats do not count if identical); without macro → 0.

Source files
------------

// File: rtl/sensor_stim_seq.sv
// GPIO stimulus sequencer: plays a loadable table of (pattern, dwell) entries once or in a loop.
// Optional edge counter is compiled in when SENSOR_STIM_SEQ_EDGE_CNT_EN is defined.
module sensor_stim_seq #(
    parameter int                WIDTH    = 8,
    parameter int                DEPTH    = 8,
    parameter int                DWELL_W  = 24,
    parameter logic [WIDTH-1:0]  IDLE_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [WIDTH-1:0]           load_pattern,
    input  logic [DWELL_W-1:0]         load_dwell,
    input  logic [$clog2(DEPTH):0]     num_steps,
    input  logic                       loop_en,
    input  logic                       start,
    input  logic                       stop,
    output logic [WIDTH-1:0]           gpio_out,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       step_strobe,
    output logic                       done,
    output logic [15:0]                edge_count
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_N = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [DWELL_W-1:0]   cnt;
    logic [AW-1:0]        last_idx;
    logic                 loop_q;

    logic [WIDTH-1:0]     pat_mem   [DEPTH];
    logic [DWELL_W-1:0]   dwell_mem [DEPTH];

    logic [AW:0]          ns_clamped;
    logic                 run_stop;
    logic                 start_go;
    logic                 expire;
    logic                 at_last;
    logic                 apply_en;
    logic [AW-1:0]        apply_idx;
    logic [WIDTH-1:0]     apply_pat;
    logic [DWELL_W-1:0]   apply_dwell;

    // Table storage is deliberately not reset; contents are undefined until loaded.
    always_ff @(posedge clk) begin
        if (load_we) begin
            pat_mem[load_addr]   <= load_pattern;
            dwell_mem[load_addr] <= load_dwell;
        end
    end

    always_comb begin
        ns_clamped  = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
        run_stop    = (state == RUN) && stop;
        start_go    = start && !stop && (ns_clamped != '0);
        expire      = (state == RUN) && (cnt <= DWELL_W'(1));
        at_last     = (step_idx == last_idx);
        apply_en    = 1'b0;
        apply_idx   = '0;
        if (!run_stop) begin
            if (start_go) begin
                apply_en = 1'b1;
            end else if (expire && (!at_last || loop_q)) begin
                apply_en  = 1'b1;
                apply_idx = at_last ? '0 : step_idx + AW'(1);
            end
        end
        apply_pat   = pat_mem[apply_idx];
        // A programmed dwell of zero is treated as a one-cycle hold.
        apply_dwell = (dwell_mem[apply_idx] == '0) ? DWELL_W'(1) : dwell_mem[apply_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gpio_out    <= IDLE_VAL;
            busy        <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            last_idx    <= '0;
            loop_q      <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (run_stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                if (start_go) begin
                    last_idx <= AW'(ns_clamped - (AW+1)'(1));
                    loop_q   <= loop_en;
                    state    <= RUN;
                    busy     <= 1'b1;
                end else if (expire && at_last && !loop_q) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else if ((state == RUN) && !expire) begin
                    cnt <= cnt - DWELL_W'(1);
                end
                if (apply_en) begin
                    gpio_out    <= apply_pat;
                    step_idx    <= apply_idx;
                    step_strobe <= 1'b1;
                    cnt         <= apply_dwell;
                end
            end
        end
    end

`ifdef SENSOR_STIM_SEQ_EDGE_CNT_EN
    logic [15:0] ec_q;

    // The start that clears the count also counts its own first entry if it changes the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ec_q <= '0;
        end else if (apply_en) begin
            if (start_go) begin
                ec_q <= (apply_pat != gpio_out) ? 16'd1 : 16'd0;
            end else if ((apply_pat != gpio_out) && (ec_q != 16'hFFFF)) begin
                ec_q <= ec_q + 16'd1;
            end
        end
    end

    assign edge_count = ec_q;
`else
    assign edge_count = '0;
`endif

endmodule
